// File: rtl/sdpb_wc_pkg.sv
// sdpb_wc_pkg: shared types and width helpers for the width-converting register file.
package sdpb_wc_pkg;
    typedef enum logic {CLEAR, READY} sdpb_wc_state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int rd_width(input int wr_width, input int rd_ratio);
        return wr_width / rd_ratio;
    endfunction
    // Lane-index signal width; kept at least one bit so RD_RATIO=1 still elaborates.
    function automatic int lane_bits(input int rd_ratio);
        return rd_ratio > 1 ? clog2(rd_ratio) : 1;
    endfunction
endpackage

// File: rtl/sdpb_wc_if.sv
// sdpb_wc_if: write/read/output bus of the width-converting register file.
interface sdpb_wc_if
    import sdpb_wc_pkg::*;
#(
    parameter int WR_WIDTH = 32,
    parameter int RD_RATIO = 2,
    parameter int WR_DEPTH = 256
);
    localparam int RW = rd_width(WR_WIDTH, RD_RATIO);
    localparam int AW = clog2(WR_DEPTH);
    localparam int LW = clog2(RD_RATIO);
    logic                  cea;
    logic [AW-1:0]         ada;
    logic [WR_WIDTH-1:0]   din;
    logic [WR_WIDTH/8-1:0] be;
    logic                  ceb;
    logic [AW+LW-1:0]      adb;
    logic                  oce;
    logic [RW-1:0]         dout;
    logic                  dout_valid;
    logic                  busy;
    modport master (output cea, ada, din, be, ceb, adb, oce, input dout, dout_valid, busy);
    modport slave  (input cea, ada, din, be, ceb, adb, oce, output dout, dout_valid, busy);
endinterface

// File: rtl/sdpb_wc_bypass.sv
// sdpb_wc_bypass: stage-1 read register that merges same-cycle write bytes into the read lane.
module sdpb_wc_bypass #(
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic          i_hit,
    input  logic [RW-1:0] i_mem,
    input  logic [RW-1:0] i_din,
    input  logic [RW-1:0] i_mask,
    output logic [RW-1:0] o_q
);
    logic [RW-1:0] w_merged;
    assign w_merged = i_hit ? (i_din & i_mask) | (i_mem & ~i_mask) : i_mem;
    always_ff @(posedge clk) begin
        if (reset) o_q <= '0;
        else if (i_en) o_q <= w_merged;
    end
endmodule

// File: rtl/sdpb_regfile_wc.sv
// sdpb_regfile_wc: width-converting simple dual-port register file with post-reset clear sweep.
// Define SDPB_WC_BYPASS_EN for write-first same-word collisions; default is read-first.
module sdpb_regfile_wc
    import sdpb_wc_pkg::*;
#(
    parameter int WR_WIDTH = 32,
    parameter int RD_RATIO = 2,
    parameter int WR_DEPTH = 256,
    parameter int OUT_REG  = 1
) (
    input  logic     clk,
    input  logic     reset,
    sdpb_wc_if.slave bus
);
    localparam int RW = rd_width(WR_WIDTH, RD_RATIO);
    localparam int AW = clog2(WR_DEPTH);
    localparam int LW = clog2(RD_RATIO);
    localparam int LS = lane_bits(RD_RATIO);
    localparam int NB = WR_WIDTH / 8;

    sdpb_wc_state_t      r_state, w_state_nxt;
    logic [AW-1:0]       r_cnt, w_cnt_nxt;
    logic [WR_WIDTH-1:0] r_mem [WR_DEPTH];
    logic                w_ready, w_wr, w_rd, r_s1v;
    logic [AW-1:0]       w_rword;
    logic [LS-1:0]       w_lane;
    logic [WR_WIDTH-1:0] w_word;
    logic [RW-1:0]       w_mem_lane, w_s1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == CLEAR) begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_state_nxt = &r_cnt ? READY : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_ready  = r_state == READY;
    assign w_wr     = bus.cea & w_ready & ~reset;
    assign w_rd     = bus.ceb & w_ready & ~reset;
    assign bus.busy = r_state == CLEAR;

    // The sweep owns the write port; user writes are only accepted once READY.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) r_mem[r_cnt] <= '0;
        else if (w_wr)
            for (int i = 0; i < NB; i++)
                if (bus.be[i]) r_mem[bus.ada][i*8 +: 8] <= bus.din[i*8 +: 8];
    end

    assign w_rword    = AW'(bus.adb >> LW);
    assign w_lane     = RD_RATIO > 1 ? LS'(bus.adb) : '0;
    assign w_word     = r_mem[w_rword];
    assign w_mem_lane = w_word[w_lane*RW +: RW];

`ifdef SDPB_WC_BYPASS_EN
    logic [WR_WIDTH-1:0] w_mask;
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) w_mask[i*8 +: 8] = {8{bus.be[i]}};
    end
    sdpb_wc_bypass #(.RW(RW)) u_bypass (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_rd),
        .i_hit  (w_wr && bus.ada == w_rword),
        .i_mem  (w_mem_lane),
        .i_din  (bus.din[w_lane*RW +: RW]),
        .i_mask (w_mask[w_lane*RW +: RW]),
        .o_q    (w_s1)
    );
`else
    logic [RW-1:0] r_s1;
    always_ff @(posedge clk) begin
        if (reset) r_s1 <= '0;
        else if (w_rd) r_s1 <= w_mem_lane;
    end
    assign w_s1 = r_s1;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_s1v <= 1'b0;
        else r_s1v <= w_rd;
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [RW-1:0] r_dout;
            logic          r_dv;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dout <= '0;
                    r_dv   <= 1'b0;
                end else if (bus.oce) begin
                    r_dout <= w_s1;
                    r_dv   <= r_s1v;
                end
            end
            assign bus.dout       = r_dout;
            assign bus.dout_valid = r_dv;
        end else begin : g_noreg
            assign bus.dout       = w_s1;
            assign bus.dout_valid = r_s1v;
        end
    endgenerate
endmodule

// File: doc/sdpb_regfile_wc.md
# sdpb_regfile_wc

Parametrised width-converting simple dual-port register-file RAM for the Next186 core: one write port of `WR_WIDTH` bits and one read port of `WR_WIDTH/RD_RATIO` bits on a single clock. It generalises the fixed 32-in/16-out register file with:

- configurable widths and depth;
- byte-enabled writes;
- an optional output register;
- a post-reset clear sweep;
- same-cycle write-to-read forwarding.

It sits between the CPU register write-back path and the operand fetch stage.

## Interface
- `WR_WIDTH`, 32: write word width; multiple of 8 and of `RD_RATIO`.
- `RD_RATIO`, 2: read lanes per write word; power of 2 (1, 2 or 4).
- `WR_DEPTH`, 256: write words; power of 2.
- `OUT_REG`, 1: 1 = registered output gated by `oce`; 0 = no output register.

Ports (derived: `RW = WR_WIDTH/RD_RATIO`, `AW = log2(WR_DEPTH)`, `LW = log2(RD_RATIO)`):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cea`  in  1  write enable.
- `ada`  in  AW  write word address.
- `din`  in  WR_WIDTH  write data.
- `be`  in  WR_WIDTH/8  byte enables for `din`; bit *i* covers `din[8i+7:8i]`.
- `ceb`  in  1  read request.
- `adb`  in  AW+LW  read lane address, `{word, lane}`.
- `oce`  in  1  output-register enable; ignored when `OUT_REG=0`.
- `dout`  out  RW  read data.
- `dout_valid`  out  1  `dout` carries the result of a read request.
- `busy`  out  1  clear sweep in progress.

## Operation
- Lane mapping: lane *k* of word *w* is `din[k*RW +: RW]`. Lane 0 is the least significant.
- State machine `CLEAR → READY`.
- **CLEAR**
  - Entered on every `reset` cycle; the counter loads 0.
  - Writes all-zero to word `cnt` each cycle, `cnt` from 0 to `WR_DEPTH-1`.
  - `cea` and `ceb` are ignored; `busy=1`.
  - Reset asserted mid-sweep restarts the sweep at 0.
- **READY**
  - `cea`: for each set `be` bit, the byte is written to word `ada`. Bytes with clear `be` keep their old value. `be=0` leaves memory unchanged.
  - `ceb`: reads lane `adb`.
  - Simultaneous `cea` and `ceb` to the same word: behaviour depends on `SDPB_WC_BYPASS_EN`; see Configuration.
  - Different words: the two operations are independent.
- Reset values: `dout=0`, `dout_valid=0`, `busy=1`. Memory contents are not reset directly; the sweep clears them.

## Timing
- Clear sweep: `busy` is high from the reset cycle through the cycle writing word `WR_DEPTH-1`. It falls on the following edge, so with default parameters the first accepted access is exactly 256 cycles after reset deasserts.
- **`OUT_REG=0`**
  - `ceb` at edge *n*: `dout`/`dout_valid` update at edge *n+1*.
  - Without `ceb`, `dout` holds its value and `dout_valid=0`.
- **`OUT_REG=1`**
  - Stage-1 data is captured at *n+1*.
  - `dout`/`dout_valid` load stage 1 at *n+2* only if `oce=1` in that cycle. Otherwise both hold.
  - A stall (`oce=0`) while a new `ceb` arrives overwrites stage 1; the older result is lost. Callers keep `oce=1` when streaming.
- Back-to-back `ceb` every cycle sustains 1 result per cycle.

## Configuration
- `SDPB_WC_BYPASS_EN` defined (write-first):
  - A read of lane *k* of word `ada` in the same cycle as a write returns the merged new value.
  - Lane bytes with `be` set come from `din`; others come from memory.
- `SDPB_WC_BYPASS_EN` not defined (read-first):
  - A same-cycle read returns the pre-write contents.
  - This matches the Gowin SDPB primitive, which lets it map to one block RAM.

## Structure
- Package `sdpb_wc_pkg`:
  - `clog2` helper;
  - `RD_WIDTH`/lane-index derivation functions;
  - state encoding typedef `sdpb_wc_state_t` (`CLEAR`, `READY`).
- Sub-module `sdpb_wc_bypass`: combinational-plus-register merge of write bytes into the read lane. Instantiated only under `SDPB_WC_BYPASS_EN`.
- Memory is an inferred array of `WR_DEPTH` × `WR_WIDTH` with byte-write; the lane mux follows the array read.

## Test plan
- **Reset/clear:** pulse reset 1 cycle → `busy=1` for exactly 256 cycles, then 0; read of `adb=0x1FF` → `dout=0x0000`, `dout_valid=1`.
- **Width conversion:** write `ada=0x05`, `din=0xDEADBEEF`, `be=4'hF`; read `adb=0x00A` then `0x00B` → `dout=0xBEEF` then `0xDEAD`, at latency 2 (`OUT_REG=1`, `oce=1`).
- **Byte enables:** over `0xDEADBEEF`, write `din=0x11223344`, `be=4'b0101` → lanes read `0xBE44`, `0xDE22`.
- **Same-cycle collision:** word `0x05` holds `0`; `cea` at `0x05` with `din=0xCAFEF00D` plus `ceb` at `0x00A` → `0xF00D` with bypass, `0x0000` without.
- **`oce` stall:** `OUT_REG=1`, reads of lanes 0, 1, 2 back-to-back with `oce=0` for 1 cycle after the first result → `dout` holds the first result during the stall; `dout_valid` stays high.
- **Reset mid-sweep:** reset at sweep count 100 → sweep restarts; `busy` stays high for a further 256 cycles; old data in word `0xFF` reads 0 afterwards.
